// File: rtl/scan_enc_pkg.sv
// -----------------------------------------------------------------------------
// scan_enc_pkg
// Shared definitions for the sequential multi-hot to index encoder:
//   - state_e      : controller state (IDLE = 0, SCAN = 1)
//   - DEFAULT_N    : default request-word width
//   - DEFAULT_W    : default emitted-index width, $clog2(DEFAULT_N)
// -----------------------------------------------------------------------------
package scan_enc_pkg;

  localparam int unsigned DEFAULT_N = 8;
  localparam int unsigned DEFAULT_W = $clog2(DEFAULT_N);

  // IDLE: waiting for a request word. SCAN: emitting indices of that word.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage : scan_enc_pkg

// File: rtl/prio_enc_lsb.sv
// -----------------------------------------------------------------------------
// prio_enc_lsb
// Purely combinational lowest-set-bit priority encoder.
// Ports:
//   pending [N-1:0] in  : bit vector to search
//   idx     [W-1:0] out : index of the lowest set bit (0 when pending == 0)
//   single          out : pending has exactly one bit set
// -----------------------------------------------------------------------------
module prio_enc_lsb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] pending,
  output logic [W-1:0] idx,
  output logic         single
);

  logic [N-1:0] pending_m1;

  // Scan from the top down so the lowest set bit is the last one to write idx.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; otherwise a path with no assignment infers a latch.
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        idx = W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero exactly when one bit was set;
  // the non-zero test excludes the empty vector.
  assign pending_m1 = pending - N'(1);
  assign single     = ((pending & pending_m1) == '0) && (pending != '0);

endmodule : prio_enc_lsb

// File: rtl/scan_encoder.sv
// -----------------------------------------------------------------------------
// scan_encoder
// Sequential N-to-log2(N) encoder. Accepts a multi-hot request word over a
// valid/ready handshake and emits the index of every set bit, lowest first,
// one index per output handshake. An all-zero word yields a single beat with
// out_none = 1 and out_idx = 0.
// Ports:
//   clk        in  : rising-edge clock
//   rst        in  : synchronous, active-high reset
//   in_valid   in  : in_bits valid this cycle
//   in_ready   out : block accepts a word this cycle (IDLE)
//   in_bits    in  : multi-hot request word [N-1:0]
//   out_valid  out : out_idx / out_last / out_none valid (SCAN)
//   out_ready  in  : consumer takes the current beat
//   out_idx    out : index of lowest remaining set bit [W-1:0]
//   out_last   out : current beat is the final beat of the word
//   out_none   out : accepted word was all zeros
//   busy       out : word in progress
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module scan_encoder
  import scan_enc_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none,
  output logic         busy
);

  state_e       state_q,   state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         none_q,    none_d;

  logic [W-1:0] enc_idx;
  logic         enc_single;
  logic [N-1:0] idx_mask;
  logic         in_fire;
  logic         out_fire;
  logic         scanning;

  prio_enc_lsb #(
    .N (N),
    .W (W)
  ) u_prio_enc (
    .pending (pending_q),
    .idx     (enc_idx),
    .single  (enc_single)
  );

  // ---------------------------------------------------------------------------
  // Output decode (registers only)
  // ---------------------------------------------------------------------------
  assign scanning  = (state_q == SCAN);
  assign in_ready  = !scanning;
  assign out_valid = scanning;
  assign busy      = scanning;
  assign out_idx   = scanning ? enc_idx : '0;
  assign out_none  = scanning && none_q;
  // A zero word is a one-beat word; otherwise the beat is last when only
  // the bit being emitted is still pending.
  assign out_last  = scanning && (none_q || enc_single);

  assign in_fire   = in_valid  && in_ready;
  assign out_fire  = out_valid && out_ready;

  // One-hot mask of the bit being emitted, used to retire it from pending.
  always_comb begin
    idx_mask          = '0;
    idx_mask[enc_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;

    unique case (state_q)
      IDLE: begin
        // in_valid during SCAN is not looked at, so nothing is queued.
        if (in_fire) begin
          state_d   = SCAN;
          pending_d = in_bits;
          none_d    = (in_bits == '0);
        end
      end

      SCAN: begin
        // Without out_ready nothing changes, which keeps the beat stable.
        if (out_fire) begin
          if (out_last) begin
            state_d   = IDLE;
            pending_d = '0;
            none_d    = 1'b0;
          end else begin
            pending_d = pending_q & ~idx_mask;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        pending_d = '0;
        none_d    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous reset aborts any word in progress)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

endmodule : scan_encoder

// File: tb/tb_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_scan_encoder
// Directed testbench for scan_encoder (N = 8). Inputs are driven 1 time unit
// after the rising edge and outputs are sampled at that point, well away from
// the active edge.
// -----------------------------------------------------------------------------
module tb_scan_encoder;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_bits;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_none;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  scan_encoder #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle-state outputs.
  task automatic check_idle(input string tag);
    check({tag, " in_ready"},  64'(in_ready),  64'd1);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " busy"},      64'(busy),      64'd0);
    check({tag, " out_idx"},   64'(out_idx),   64'd0);
    check({tag, " out_last"},  64'(out_last),  64'd0);
    check({tag, " out_none"},  64'(out_none),  64'd0);
  endtask

  // Present a word for one edge; the DUT must be idle, so it is accepted.
  task automatic send_word(input logic [N-1:0] bits);
    in_valid = 1'b1;
    in_bits  = bits;
    step();
    in_valid = 1'b0;
    in_bits  = '0;
  endtask

  // Check the beat on display, then advance one cycle with the given out_ready.
  task automatic check_beat(input string tag, input int idx, input bit last,
                            input bit none, input bit take);
    out_ready = take;
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " in_ready"},  64'(in_ready),  64'd0);
    check({tag, " busy"},      64'(busy),      64'd1);
    check({tag, " out_idx"},   64'(out_idx),   64'(idx));
    check({tag, " out_last"},  64'(out_last),  64'(last));
    check({tag, " out_none"},  64'(out_none),  64'(none));
    step();
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bits   = '0;
    out_ready = 1'b1;

    // Reset held for two edges, then released.
    step();
    step();
    rst = 1'b0;
    step();
    check_idle("reset");

    // Single bit 0: one beat, then idle on the following cycle.
    send_word(8'b0000_0001);
    check_beat("w01", 0, 1'b1, 1'b0, 1'b1);
    check_idle("w01 done");

    // Three bits: 2, 5, 7 back to back.
    send_word(8'b1010_0100);
    check_beat("wA4 b0", 2, 1'b0, 1'b0, 1'b1);
    check_beat("wA4 b1", 5, 1'b0, 1'b0, 1'b1);
    check_beat("wA4 b2", 7, 1'b1, 1'b0, 1'b1);
    check_idle("wA4 done");

    // Same word with backpressure on the first beat, and in_valid noise
    // during SCAN that must not be captured.
    send_word(8'b1010_0100);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bits  = 8'hFF;
      check_beat($sformatf("hold %0d", i), 2, 1'b0, 1'b0, 1'b0);
    end
    check_beat("hold take", 2, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    in_bits  = '0;
    check_beat("hold b1", 5, 1'b0, 1'b0, 1'b1);
    check_beat("hold b2", 7, 1'b1, 1'b0, 1'b1);
    check_idle("hold done");
    // Stay idle one more cycle: no queued word may appear.
    step();
    check_idle("no queued word");

    // All-zero word: one beat flagged none.
    send_word(8'h00);
    check_beat("zero", 0, 1'b1, 1'b1, 1'b1);
    check_idle("zero done");

    // All-ones word: eight consecutive beats.
    send_word(8'hFF);
    for (int i = 0; i < 8; i++) begin
      check_beat($sformatf("ff b%0d", i), i, (i == 7), 1'b0, 1'b1);
    end
    check_idle("ff done");

    // Back-to-back words: the next word goes in the cycle after the last beat.
    send_word(8'b1000_0000);
    check_beat("w80", 7, 1'b1, 1'b0, 1'b1);
    send_word(8'b0000_0110);
    check_beat("w06 b0", 1, 1'b0, 1'b0, 1'b1);
    check_beat("w06 b1", 2, 1'b1, 1'b0, 1'b1);
    check_idle("w06 done");

    // Reset mid-word aborts the remaining beats.
    send_word(8'b1100_0011);
    check_beat("wC3 b0", 0, 1'b0, 1'b0, 1'b1);
    check("wC3 b1 idx before rst", 64'(out_idx), 64'd1);
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    check_idle("mid reset");
    send_word(8'b0001_0000);
    check_beat("w10", 4, 1'b1, 1'b0, 1'b1);
    check_idle("w10 done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_scan_encoder
